// File: rtl/mem_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Holds the FSM state encoding, grant-select encoding and memsize values.
package mem_pkg;

   // Width of the core's memsize access-size encoding
   localparam int MSZ_W = 3;

   // memsize code for a 32-bit word access (used for every fetch)
   localparam logic [MSZ_W-1:0] MEMSIZE_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } arb_state_t;

   typedef enum logic {
      SEL_I,
      SEL_D
   } arb_sel_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick between fetch and load/store requesters.
// Ports: req_i/req_d pending requests, last side granted, sel chosen side.
module arb_rr2
   import mem_pkg::*;
(
   input  logic     req_i,
   input  logic     req_d,
   input  arb_sel_t last,
   output arb_sel_t sel
);

   // Under contention the side not served last wins. With a single
   // requester that side wins. With none the value is unused by the
   // caller, so fetch is returned as a harmless default.
   always_comb begin
      sel = SEL_I;
      if (req_i && req_d) begin
         sel = (last == SEL_D) ? SEL_I : SEL_D;
      end else if (req_d) begin
         sel = SEL_D;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store,
// one transaction in flight, round-robin when both sides are pending.
// Ports: clk/reset; i_* fetch side; d_* load/store side; m_* memory port.
// Requests are levels held until the one-cycle *_valid completion pulse.
// Every output is a register; no input reaches an output combinationally.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic             clk,
   input  logic             reset,

   input  logic             i_req,
   input  logic [AW-1:0]    i_addr,
   output logic [DW-1:0]    i_rdata,
   output logic             i_valid,

   input  logic             d_req,
   input  logic             d_we,
   input  logic [MSZ_W-1:0] d_size,
   input  logic [AW-1:0]    d_addr,
   input  logic [DW-1:0]    d_wdata,
   output logic [DW-1:0]    d_rdata,
   output logic             d_valid,

   output logic             m_req,
   output logic             m_we,
   output logic [MSZ_W-1:0] m_size,
   output logic [AW-1:0]    m_addr,
   output logic [DW-1:0]    m_wdata,
   input  logic             m_gnt,
   input  logic             m_rvalid,
   input  logic [DW-1:0]    m_rdata
);

   arb_state_t state;
   arb_sel_t   sel;
   arb_sel_t   last;
   arb_sel_t   pick;

   arb_rr2 u_rr (
      .req_i (i_req),
      .req_d (d_req),
      .last  (last),
      .sel   (pick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         sel     <= SEL_I;
         last    <= SEL_D;
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_size  <= '0;
         m_addr  <= '0;
         m_wdata <= '0;
         i_rdata <= '0;
         d_rdata <= '0;
         i_valid <= 1'b0;
         d_valid <= 1'b0;
      end else begin
         // Completion flags are single-cycle pulses
         i_valid <= 1'b0;
         d_valid <= 1'b0;

         unique case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  sel   <= pick;
                  last  <= pick;
                  m_req <= 1'b1;
                  state <= REQ;
                  if (pick == SEL_I) begin
                     // Fetch is always a word read
                     m_addr  <= i_addr;
                     m_we    <= 1'b0;
                     m_size  <= MEMSIZE_WORD;
                     m_wdata <= '0;
                  end else begin
                     m_addr  <= d_addr;
                     m_we    <= d_we;
                     m_size  <= d_size;
                     m_wdata <= d_wdata;
                  end
               end
            end

            REQ: begin
               // m_* stay frozen until memory accepts; a stray
               // m_rvalid here belongs to nothing and is dropped
               if (m_gnt) begin
                  m_req <= 1'b0;
                  state <= WAIT;
               end
            end

            WAIT: begin
               if (m_rvalid) begin
                  state <= DONE;
                  if (sel == SEL_I) begin
                     i_rdata <= m_rdata;
                     i_valid <= 1'b1;
                  end else begin
                     d_rdata <= m_rdata;
                     d_valid <= 1'b1;
                  end
               end
            end

            DONE: begin
               // Requests are ignored while the pulse is visible, so a
               // requester has this cycle to drop or renew its level
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus
// hand-written contention, stale-response, reset and held-request cases.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_valid;
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        m_req;
   logic        m_we;
   logic [2:0]  m_size;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_rdata  (i_rdata),
      .i_valid  (i_valid),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_size   (d_size),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .d_valid  (d_valid),
      .m_req    (m_req),
      .m_we     (m_we),
      .m_size   (m_size),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_gnt    (m_gnt),
      .m_rvalid (m_rvalid),
      .m_rdata  (m_rdata)
   );

   typedef struct {
      bit          side;
      logic [31:0] addr;
      logic        we;
      logic [2:0]  size;
      logic [31:0] wdata;
      int          gdly;
      int          rdly;
      logic [31:0] rdata;
      logic        exp_we;
      logic [2:0]  exp_size;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_v(input string nm, input logic ei, input logic ed);
      chk({nm, " i_valid"}, {31'd0, i_valid}, {31'd0, ei});
      chk({nm, " d_valid"}, {31'd0, d_valid}, {31'd0, ed});
   endtask

   task automatic idle_inputs();
      i_req    = 1'b0;
      d_req    = 1'b0;
      m_gnt    = 1'b0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, " m_req"}, {31'd0, m_req}, 32'd0);
      chk({nm, " m_we"}, {31'd0, m_we}, 32'd0);
      chk({nm, " m_size"}, {29'd0, m_size}, 32'd0);
      chk({nm, " m_addr"}, m_addr, 32'd0);
      chk({nm, " m_wdata"}, m_wdata, 32'd0);
      chk({nm, " i_rdata"}, i_rdata, 32'd0);
      chk({nm, " d_rdata"}, d_rdata, 32'd0);
      chk_v(nm, 1'b0, 1'b0);
   endtask

   // One isolated transaction, starting and ending in IDLE
   task automatic run_vec(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("vec%0d", idx);
      if (v.side) begin
         d_addr = v.addr;
         i_addr = 32'hFFFF_0000;
         d_req  = 1'b1;
      end else begin
         i_addr = v.addr;
         d_addr = 32'hEEEE_0000;
         i_req  = 1'b1;
      end
      d_we    = v.we;
      d_size  = v.size;
      d_wdata = v.wdata;
      tick();
      for (int k = 0; k <= v.gdly; k++) begin
         chk({nm, " m_req"}, {31'd0, m_req}, 32'd1);
         chk({nm, " m_addr"}, m_addr, v.addr);
         chk({nm, " m_we"}, {31'd0, m_we}, {31'd0, v.exp_we});
         chk({nm, " m_size"}, {29'd0, m_size}, {29'd0, v.exp_size});
         if (v.side)
            chk({nm, " m_wdata"}, m_wdata, v.wdata);
         if (k == v.gdly)
            m_gnt = 1'b1;
         tick();
      end
      m_gnt = 1'b0;
      chk({nm, " wait m_req"}, {31'd0, m_req}, 32'd0);
      for (int k = 0; k < v.rdly; k++) begin
         chk_v({nm, " wait"}, 1'b0, 1'b0);
         tick();
      end
      chk_v({nm, " pre"}, 1'b0, 1'b0);
      m_rvalid = 1'b1;
      m_rdata  = v.rdata;
      tick();
      m_rvalid = 1'b0;
      m_rdata  = 32'h5A5A_5A5A;
      i_req    = 1'b0;
      d_req    = 1'b0;
      chk_v({nm, " done"}, !v.side, v.side);
      if (v.side)
         chk({nm, " d_rdata"}, d_rdata, v.rdata);
      else
         chk({nm, " i_rdata"}, i_rdata, v.rdata);
      tick();
      chk_v({nm, " after"}, 1'b0, 1'b0);
      chk({nm, " after m_req"}, {31'd0, m_req}, 32'd0);
      tick();
      chk({nm, " idle m_req"}, {31'd0, m_req}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      i_addr  = '0;
      d_we    = 1'b0;
      d_size  = '0;
      d_addr  = '0;
      d_wdata = '0;
      do_reset();
      chk_reset_outs("reset");

      // side addr we size wdata gdly rdly rdata exp_we exp_size
      vecs[0] = '{1'b0, 32'h0000_0100, 1'b1, 3'b000, 32'h0,
                  0, 0, 32'h0050_0093, 1'b0, 3'b010};
      vecs[1] = '{1'b1, 32'h0000_2004, 1'b1, 3'b000, 32'h0000_00AB,
                  3, 0, 32'h0000_0000, 1'b1, 3'b000};
      vecs[2] = '{1'b1, 32'h0000_3000, 1'b0, 3'b100, 32'h1234_5678,
                  0, 2, 32'hDEAD_BEEF, 1'b0, 3'b100};
      vecs[3] = '{1'b0, 32'h0000_0204, 1'b1, 3'b001, 32'h0,
                  1, 1, 32'hFE01_0113, 1'b0, 3'b010};
      for (int i = 0; i < 4; i++)
         run_vec(vecs[i], i);

      // Contention: both held high, grants I, D, I, D
      do_reset();
      i_addr = 32'h0000_0040;
      d_addr = 32'h0000_0080;
      d_we   = 1'b0;
      d_size = 3'b010;
      i_req  = 1'b1;
      d_req  = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         chk($sformatf("cont%0d m_req", t), {31'd0, m_req}, 32'd1);
         chk($sformatf("cont%0d m_addr", t), m_addr,
             (t % 2 == 0) ? 32'h40 : 32'h80);
         m_gnt = 1'b1;
         tick();
         m_gnt    = 1'b0;
         m_rvalid = 1'b1;
         m_rdata  = 32'h100 + t;
         tick();
         m_rvalid = 1'b0;
         if (t == 3) begin
            i_req = 1'b0;
            d_req = 1'b0;
         end
         chk_v($sformatf("cont%0d", t), t % 2 == 0, t % 2 == 1);
         tick();
         chk($sformatf("cont%0d gap", t), {31'd0, m_req}, 32'd0);
      end
      chk("cont i_rdata", i_rdata, 32'h102);
      chk("cont d_rdata", d_rdata, 32'h103);

      // Stale response while in REQ
      d_addr = 32'h0000_5000;
      d_req  = 1'b1;
      tick();
      m_rvalid = 1'b1;
      m_rdata  = 32'hBAD0_BAD0;
      tick();
      m_rvalid = 1'b0;
      chk("stale m_req", {31'd0, m_req}, 32'd1);
      chk_v("stale req", 1'b0, 1'b0);
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      chk("stale wait m_req", {31'd0, m_req}, 32'd0);
      tick();
      chk_v("stale wait", 1'b0, 1'b0);
      m_rvalid = 1'b1;
      m_rdata  = 32'h600D_0001;
      tick();
      m_rvalid = 1'b0;
      d_req    = 1'b0;
      chk_v("stale done", 1'b0, 1'b1);
      chk("stale d_rdata", d_rdata, 32'h600D_0001);
      tick();

      // Reset mid-WAIT after a fetch left last = fetch
      i_addr = 32'h0000_0300;
      i_req  = 1'b1;
      tick();
      m_gnt = 1'b1;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'h7777_0001;
      tick();
      m_rvalid = 1'b0;
      tick();
      chk("rst pre i_rdata", i_rdata, 32'h7777_0001);
      tick();
      chk("rst pre m_req", {31'd0, m_req}, 32'd1);
      m_gnt = 1'b1;
      tick();
      m_gnt = 1'b0;
      chk("rst in wait", {31'd0, m_req}, 32'd0);
      reset = 1'b1;
      i_req = 1'b0;
      tick();
      reset = 1'b0;
      chk_reset_outs("rst mid");
      m_rvalid = 1'b1;
      m_rdata  = 32'hDEAD_0000;
      tick();
      m_rvalid = 1'b0;
      chk_v("rst late rsp", 1'b0, 1'b0);
      chk("rst late m_req", {31'd0, m_req}, 32'd0);
      i_addr = 32'h0000_0400;
      d_addr = 32'h0000_0800;
      i_req  = 1'b1;
      d_req  = 1'b1;
      tick();
      chk("rst first grant", m_addr, 32'h400);
      i_req = 1'b0;
      d_req = 1'b0;
      m_gnt = 1'b1;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'h0;
      tick();
      m_rvalid = 1'b0;
      tick();

      // Fetch request held through DONE starts a second fetch
      i_addr = 32'h0000_0500;
      i_req  = 1'b1;
      tick();
      m_gnt = 1'b1;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'h1111_2222;
      tick();
      m_rvalid = 1'b0;
      chk_v("held done", 1'b1, 1'b0);
      tick();
      chk("held idle m_req", {31'd0, m_req}, 32'd0);
      tick();
      chk("held second m_req", {31'd0, m_req}, 32'd1);
      chk("held second addr", m_addr, 32'h500);
      i_req = 1'b0;
      m_gnt = 1'b1;
      tick();
      m_gnt    = 1'b0;
      m_rvalid = 1'b1;
      m_rdata  = 32'h3333_4444;
      tick();
      m_rvalid = 1'b0;
      chk_v("held second done", 1'b1, 1'b0);
      chk("held second rdata", i_rdata, 32'h3333_4444);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
